// File: rtl/imem_pkg.sv
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 6;
  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned IMEM_DEPTH  = 64;

  typedef logic [IMEM_DATA_W-1:0] instr_t;
  typedef logic [IMEM_ADDR_W-1:0] imem_addr_t;

  localparam instr_t NOP = 32'h0000_0000;

  localparam instr_t IMEM_DEFAULT_PROG [0:IMEM_DEPTH-1] = '{
    0:       32'h2008_0005,
    1:       32'h2009_000A,
    2:       32'h0109_5020,
    3:       32'h0109_5822,
    4:       32'h0109_6024,
    5:       32'h0109_6825,
    6:       32'h0109_702A,
    7:       32'hAC0A_0000,
    8:       32'h0800_0000,
    default: NOP
  };

  localparam instr_t IMEM_FILE_PROG [0:IMEM_DEPTH-1] = '{
    0:       32'hDEAD_BEEF,
    63:      32'h1234_5678,
    default: NOP
  };

endpackage

// File: rtl/instruction_rom.sv
// Combinational word-index to instruction lookup over the built-in program.
module instruction_rom
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = IMEM_DATA_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);

    always_comb begin
        word = DATA_W'(IMEM_DEFAULT_PROG[addr]);
    end

endmodule

// File: rtl/instruction_memory.sv
module instruction_memory
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] ReadData
);

  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] rdata_q = '0;

`ifdef IMEM_LOADFILE_EN
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  initial begin
    for (int unsigned i = 0; i < 2**ADDR_W; i++) begin
      mem[i] = DATA_W'(NOP);
    end
    for (int unsigned i = 0; i < 2**ADDR_W && i < IMEM_DEPTH; i++) begin
      mem[i] = DATA_W'(IMEM_FILE_PROG[i]);
    end
  end

  always_comb begin
    word = mem[Addr];
  end
`else
  instruction_rom #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rom (
    .addr(Addr),
    .word(word)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= word;
    end
  end

  assign ReadData = rdata_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: expected words are queued when an
// address is driven and popped after the sampling edge.
module tb_instruction_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  Addr;
    logic [31:0] ReadData;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [0:63];
    logic [5:0]  pc;

    always #10 clk = ~clk;

    instruction_memory #(
        .ADDR_W(6),
        .DATA_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Addr(Addr),
        .ReadData(ReadData)
    );

    task automatic check(input string tag, input logic [31:0] expv);
        vectors++;
        assert (ReadData === expv) else begin
            miscompares++;
            $error("FAIL %s: ReadData=%08h expected=%08h", tag, ReadData, expv);
        end
    endtask

    // Drive away from the active edge, then compare just after it.
    task automatic step(input logic [5:0] a, input logic r, input string tag);
        logic [31:0] e;
        @(negedge clk);
        Addr  = a;
        rst_n = r;
        exp_q.push_back(r ? ref_mem[a] : 32'h0000_0000);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, e);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0000_0000;
`ifdef IMEM_LOADFILE_EN
        ref_mem[0]  = 32'hDEAD_BEEF;
        ref_mem[63] = 32'h1234_5678;
`else
        ref_mem[0] = 32'h2008_0005;
        ref_mem[1] = 32'h2009_000A;
        ref_mem[2] = 32'h0109_5020;
        ref_mem[3] = 32'h0109_5822;
        ref_mem[4] = 32'h0109_6024;
        ref_mem[5] = 32'h0109_6825;
        ref_mem[6] = 32'h0109_702A;
        ref_mem[7] = 32'hAC0A_0000;
        ref_mem[8] = 32'h0800_0000;
`endif

        rst_n = 1'b0;
        Addr  = 6'd2;
        #1;
        check("power_up", 32'h0000_0000);

        step(6'd2, 1'b0, "reset_1");
        step(6'd2, 1'b0, "reset_2");
        step(6'd2, 1'b1, "release");

        // Sweep with wrap from 63; one reset cycle lands on PC=5 of the second pass.
        pc = 6'd63;
        for (int i = 0; i < 300; i++) begin
            if (i == 70) step(pc, 1'b0, "midstream_reset");
            else         step(pc, 1'b1, "sweep");
            pc = pc + 6'd1;
        end

        step(6'd63, 1'b1, "wrap_63");
        step(6'd0,  1'b1, "wrap_0");
        step(6'd1,  1'b1, "word_1");

        // No combinational path: a mid-cycle address change must not reach the output.
        #8;
        Addr = 6'd7;
        #1;
        check("latency_hold", ref_mem[1]);
        step(6'd7, 1'b1, "latency_update");

        step(6'd8, 1'b1, "jump");
        step(6'd9, 1'b1, "first_nop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
